nexus_work_dispatcher: RTL and testbench

//  Host-side counterpart of NexusHashTransform: assembles a work packet plus start nonce from a

---
 rtl/nexus_work_dispatcher.sv | 170 +++++++++++++++++
 tb/tb_nexus_work_dispatcher.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nexus_work_dispatcher.sv
// Host-side bridge for one NexusHashTransform: loads work packet + start nonce from a byte
// stream, sequences the hasher reset, and streams found nonces back out as bytes.
module nexus_work_dispatcher #(
  parameter int PKT_BITS   = 1728,
  parameter int NONCE_BITS = 64,
  parameter int FIFO_DEPTH = 4,
  parameter int RST_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [PKT_BITS-1:0]   work_pkt,
  output logic [NONCE_BITS-1:0] in_nonce,
  output logic                  n_hash_rst,
  input  logic [NONCE_BITS-1:0] nonce_in,
  input  logic                  nonce_found,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  overflow
);

  localparam int FRAME_BITS  = PKT_BITS + NONCE_BITS;
  localparam int FRAME_BYTES = FRAME_BITS / 8;
  localparam int CNT_W       = $clog2(FRAME_BYTES);
  localparam int HOLD_W      = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int PTR_W       = $clog2(FIFO_DEPTH);
  localparam int TX_BYTES    = NONCE_BITS / 8;
  localparam int TXC_W       = (TX_BYTES > 1) ? $clog2(TX_BYTES) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_RUN} state_e;

  // ---------------- frame loader ----------------
  logic [CNT_W-1:0]      rx_cnt_q;
  logic [FRAME_BITS-1:0] shadow_q;
  logic                  commit_q;
  logic                  rx_fire, rx_last;

  assign rx_ready = ~rst;
  assign rx_fire  = rx_valid & rx_ready;
  assign rx_last  = (rx_cnt_q == CNT_W'(FRAME_BYTES - 1));

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      rx_cnt_q <= '0;
      commit_q <= 1'b0;
    end else begin
      commit_q <= rx_fire & rx_last;
      if (rx_fire) rx_cnt_q <= rx_last ? '0 : rx_cnt_q + CNT_W'(1);
    end
  end

  // NOTE: no reset on the shadow or FIFO storage; a complete frame / a push always overwrites
  // what is later read, and the counters/pointers that qualify them are reset.
  always_ff @(posedge clk) begin
    if (rx_fire) shadow_q <= {shadow_q[FRAME_BITS-9:0], rx_data};
  end

  // ---------------- hasher reset sequencer ----------------
  state_e                state_q, state_d;
  logic [HOLD_W-1:0]     hold_q, hold_d;
  logic                  n_hash_rst_q;
  logic [PKT_BITS-1:0]   work_pkt_q;
  logic [NONCE_BITS-1:0] in_nonce_q;

  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      ST_HOLD: begin
        if (hold_q == '0) state_d = ST_RUN;
        else              hold_d  = hold_q - HOLD_W'(1);
      end
      default: ;
    endcase
    // A new packet always (re)starts the hold window, whatever the current state.
    if (commit_q) begin
      state_d = ST_HOLD;
      hold_d  = HOLD_W'(RST_CYCLES - 1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      hold_q       <= '0;
      n_hash_rst_q <= 1'b0;
      work_pkt_q   <= '0;
      in_nonce_q   <= '0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      n_hash_rst_q <= (state_d == ST_RUN);
      if (commit_q) {work_pkt_q, in_nonce_q} <= shadow_q;
    end
  end

  assign work_pkt   = work_pkt_q;
  assign in_nonce   = in_nonce_q;
  assign n_hash_rst = n_hash_rst_q;

  // ---------------- found-nonce FIFO ----------------
  logic [NONCE_BITS-1:0] fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W:0]        wr_ptr_q, rd_ptr_q;
  logic                  overflow_q;
  logic                  fifo_empty, fifo_full, capture, push, tx_release;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  // Stale results from before/during the hasher reset are never queued.
  assign capture    = nonce_found && (state_q == ST_RUN);
  assign push       = capture && (!fifo_full || tx_release);

  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q[PTR_W-1:0]] <= nonce_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push)       wr_ptr_q <= wr_ptr_q + (PTR_W+1)'(1);
      if (tx_release) rd_ptr_q <= rd_ptr_q + (PTR_W+1)'(1);
      if (capture && fifo_full && !tx_release) overflow_q <= 1'b1;
    end
  end

  assign overflow = overflow_q;

  // ---------------- byte transmitter ----------------
  // The entry being sent keeps its FIFO slot until its last byte is accepted.
  logic [NONCE_BITS-1:0] tx_shift_q;
  logic [TXC_W-1:0]      tx_cnt_q;
  logic                  tx_valid_q;

  assign tx_release = tx_valid_q && tx_ready && (tx_cnt_q == TXC_W'(TX_BYTES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_shift_q <= '0;
      tx_cnt_q   <= '0;
      tx_valid_q <= 1'b0;
    end else if (!tx_valid_q) begin
      if (!fifo_empty) begin
        tx_shift_q <= fifo_mem_q[rd_ptr_q[PTR_W-1:0]];
        tx_cnt_q   <= '0;
        tx_valid_q <= 1'b1;
      end
    end else if (tx_ready) begin
      tx_shift_q <= tx_shift_q << 8;
      if (tx_release) begin
        tx_cnt_q   <= '0;
        tx_valid_q <= 1'b0;
      end else begin
        tx_cnt_q   <= tx_cnt_q + TXC_W'(1);
      end
    end
  end

  assign tx_data  = tx_shift_q[NONCE_BITS-1 -: 8];
  assign tx_valid = tx_valid_q;

endmodule

// File: tb/tb_nexus_work_dispatcher.sv
// Bench for nexus_work_dispatcher: randomized frames/nonces, expected tx bytes queued by the
// stimulus side and consumed by an independent output monitor.
module tb_nexus_work_dispatcher;

  localparam int PKT_BITS    = 1728;
  localparam int NONCE_BITS  = 64;
  localparam int FIFO_DEPTH  = 4;
  localparam int RST_CYCLES  = 4;
  localparam int FRAME_BITS  = PKT_BITS + NONCE_BITS;
  localparam int FRAME_BYTES = FRAME_BITS / 8;
  localparam int NB          = NONCE_BITS / 8;

  typedef logic [FRAME_BITS-1:0] frame_t;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [7:0]            rx_data = '0;
  logic                  rx_valid = 1'b0;
  logic                  rx_ready;
  logic [PKT_BITS-1:0]   work_pkt;
  logic [NONCE_BITS-1:0] in_nonce;
  logic                  n_hash_rst;
  logic [NONCE_BITS-1:0] nonce_in = '0;
  logic                  nonce_found = 1'b0;
  logic [7:0]            tx_data;
  logic                  tx_valid;
  logic                  tx_ready = 1'b0;
  logic                  overflow;

  nexus_work_dispatcher #(
    .PKT_BITS(PKT_BITS), .NONCE_BITS(NONCE_BITS),
    .FIFO_DEPTH(FIFO_DEPTH), .RST_CYCLES(RST_CYCLES)
  ) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .work_pkt(work_pkt), .in_nonce(in_nonce), .n_hash_rst(n_hash_rst),
    .nonce_in(nonce_in), .nonce_found(nonce_found),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0]          exp_bytes[$];
  int                  bytes_seen = 0;
  bit                  model_run = 1'b0;
  bit                  overflow_exp = 1'b0;
  bit                  tx_rand = 1'b0;
  logic [PKT_BITS-1:0] cur_pkt = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_pkt(input string name, input logic [PKT_BITS-1:0] act,
                           input logic [PKT_BITS-1:0] exp);
    int idx;
    checks++;
    if (act !== exp) begin
      errors++;
      idx = 0;
      for (int i = 0; i < PKT_BITS/8; i++) begin
        if (act[PKT_BITS-1-8*i -: 8] !== exp[PKT_BITS-1-8*i -: 8]) begin
          idx = i;
          break;
        end
      end
      $display("FAIL %s: first bad byte %0d got %h expected %h", name, idx,
               act[PKT_BITS-1-8*idx -: 8], exp[PKT_BITS-1-8*idx -: 8]);
    end
  endtask

  // Output monitor: every accepted tx byte must be the next expected one; stalled bytes hold.
  initial begin : monitor
    logic [7:0] e;
    logic [7:0] stall_data;
    bit         stall_q;
    stall_q = 1'b0;
    stall_data = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_q = 1'b0;
      end else begin
        if (stall_q) begin
          check("tx_hold_valid", tx_valid, 1);
          check("tx_hold_data", tx_data, stall_data);
        end
        stall_q    = tx_valid && !tx_ready;
        stall_data = tx_data;
        if (tx_valid && tx_ready) begin
          if (exp_bytes.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL tx_unexpected: got byte %h expected none", tx_data);
          end else begin
            e = exp_bytes.pop_front();
            check("tx_byte", tx_data, e);
          end
          bytes_seen++;
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timed out");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (tx_rand) tx_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) tick();
    exp_bytes.delete();
    rst = 1'b0;
    model_run = 1'b0;
    overflow_exp = 1'b0;
    cur_pkt = '0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_bytes(input frame_t f, input int first, input int last, input bit gaps);
    for (int i = first; i <= last; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) tick();
      send_byte(f[FRAME_BITS-1-8*i -: 8]);
    end
  endtask

  // Whole frame; outputs must still show the previous packet until the last byte lands.
  task automatic load_frame(input frame_t f, input bit gaps);
    send_bytes(f, 0, FRAME_BYTES-2, gaps);
    check_pkt("no_early_commit", work_pkt, cur_pkt);
    send_byte(f[7:0]);
  endtask

  // Called right after the last-byte edge N; ends just after edge N+1+RST_CYCLES.
  task automatic expect_commit(input frame_t f, input bit stale, input logic [63:0] stale_val);
    tick();
    check_pkt("commit_work_pkt", work_pkt, f[FRAME_BITS-1 -: PKT_BITS]);
    check("commit_in_nonce", in_nonce, f[NONCE_BITS-1:0]);
    check("hold_start", n_hash_rst, 0);
    if (stale) begin
      nonce_in    = stale_val;
      nonce_found = 1'b1;
    end
    for (int k = 2; k <= RST_CYCLES; k++) begin
      tick();
      nonce_found = 1'b0;
      check("hold_low", n_hash_rst, 0);
    end
    tick();
    nonce_found = 1'b0;
    check("hold_release", n_hash_rst, 1);
    cur_pkt   = f[FRAME_BITS-1 -: PKT_BITS];
    model_run = 1'b1;
  endtask

  // One-cycle found pulse; model: accepted in RUN while fewer than FIFO_DEPTH nonces unsent.
  task automatic pulse(input logic [63:0] v);
    int occ;
    occ = (exp_bytes.size() + NB - 1) / NB;
    nonce_in    = v;
    nonce_found = 1'b1;
    if (model_run) begin
      if (occ < FIFO_DEPTH) begin
        for (int b = 0; b < NB; b++) exp_bytes.push_back(v[63-8*b -: 8]);
      end else begin
        overflow_exp = 1'b1;
      end
    end
    tick();
    nonce_found = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_bytes.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check("drain_remaining", exp_bytes.size(), 0);
    exp_bytes.delete();
  endtask

  function automatic frame_t rand_frame();
    frame_t f;
    for (int w = 0; w < FRAME_BITS/32; w++) f[32*w +: 32] = $urandom();
    return f;
  endfunction

  initial begin : stim
    frame_t f;
    int     base, n;

    // T1: reset
    do_reset(3);
    rst = 1'b1;
    check("rst_n_hash_rst", n_hash_rst, 0);
    check("rst_rx_ready", rx_ready, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_overflow", overflow, 0);
    check("rst_in_nonce", in_nonce, 0);
    check_pkt("rst_work_pkt", work_pkt, '0);
    rst = 1'b0;
    #1;
    check("rx_ready_after_rst", rx_ready, 1);

    // T2: reference packet and start nonce
    f = rand_frame();
    f[FRAME_BITS-1 -: 32]     = 32'h38DD0C44;
    f[NONCE_BITS+640 +: 24]   = 24'h5D838A;
    f[NONCE_BITS-1:0]         = 64'h00000001FCAFC044;
    send_bytes(f, 0, FRAME_BYTES-2, 1'b0);
    check_pkt("no_early_commit", work_pkt, '0);
    check("idle_n_hash_rst", n_hash_rst, 0);
    send_byte(f[7:0]);
    expect_commit(f, 1'b0, '0);

    // T3: single found nonce
    tx_ready = 1'b1;
    pulse(64'h00000001FCAFC0A7);
    wait_drain(50);
    tick();
    check("t3_tx_idle", tx_valid, 0);
    check("t3_overflow", overflow, overflow_exp);

    // T4: backpressure and overflow
    tx_ready = 1'b0;
    for (int v = 1; v <= 5; v++) pulse(64'(v));
    check("t4_overflow_set", overflow, overflow_exp);
    tx_ready = 1'b1;
    wait_drain(200);
    check("t4_overflow_sticky", overflow, overflow_exp);

    // Randomized frames, nonces and sink backpressure
    tx_rand = 1'b1;
    for (int r = 0; r < 6; r++) begin
      f = rand_frame();
      load_frame(f, 1'b1);
      expect_commit(f, 1'b0, '0);
      n = $urandom_range(1, 3);
      for (int p = 0; p < n; p++) begin
        repeat ($urandom_range(0, 3)) tick();
        pulse({$urandom(), $urandom()});
      end
      wait_drain(400);
    end
    tx_rand  = 1'b0;
    tx_ready = 1'b1;

    // T6: reset mid-frame, then a clean frame
    f = rand_frame();
    send_bytes(f, 0, 99, 1'b0);
    do_reset(2);
    check_pkt("t6_pkt_cleared", work_pkt, '0);
    check("t6_overflow_cleared", overflow, 0);
    f = rand_frame();
    load_frame(f, 1'b0);
    expect_commit(f, 1'b0, '0);

    // T6: reset while the fourth byte of a nonce is presented
    base = bytes_seen;
    pulse({$urandom(), $urandom()});
    n = 0;
    while (bytes_seen - base < 3 && n < 100) begin
      tick();
      n++;
    end
    check("t6_tx_progress", bytes_seen - base, 3);
    rst = 1'b1;
    tick();
    check("t6_tx_valid_rst", tx_valid, 0);
    check("t6_tx_data_rst", tx_data, 0);
    check("t6_n_hash_rst_rst", n_hash_rst, 0);
    do_reset(2);
    repeat (20) tick();
    check("t6_fifo_empty", tx_valid, 0);

    // T5: stale drop during HOLD with a full FIFO that survives the commit
    f = rand_frame();
    load_frame(f, 1'b0);
    expect_commit(f, 1'b0, '0);
    tx_ready = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) pulse({$urandom(), $urandom()});
    check("t5_full_no_overflow", overflow, overflow_exp);
    f = rand_frame();
    load_frame(f, 1'b0);
    expect_commit(f, 1'b1, 64'hDEADBEEF0BADF00D);
    check("t5_stale_no_overflow", overflow, overflow_exp);
    tx_ready = 1'b1;
    wait_drain(200);
    pulse(64'h0123456789ABCDEF);
    wait_drain(50);
    check("t5_overflow_final", overflow, overflow_exp);
    repeat (10) tick();
    check("t5_tx_idle", tx_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
